gen2_frame_assembler: RTL and testbench
=======================================

Name: gen2_frame_assembler

Overview:
- Sits directly downstream of preamble_detector; consumes its recovered bit stream (out_dat/out_vld), frequency_bank and preamble/postamble pulses.
- Collects the bits following each detected preamble into one tag reply frame (RN16, EPC, handle), terminated by bit count, postamble or timeout.
- Presents the frame with length, bank, error code and CRC status to the reader control logic over a valid/ready handshake.

Parameters:
- MAX_BITS, 128, frame buffer capacity in bits.
- BANKS, 4, number of frequency banks; BANK_WIDTH = $clog2(BANKS) (localparam).
- TIMEOUT, 255, max clk cycles without in_vld while collecting before abort.
- LEN_WIDTH = $clog2(MAX_BITS+1) (localparam).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_dat  input  1  data bit from preamble_detector out_dat
- in_vld  input  1  bit strobe from preamble_detector out_vld
- in_bank  input  BANK_WIDTH  frequency_bank from preamble_detector
- preamble_detected  input  1  single-cycle pulse, frame start
- postamble_detected  input  1  single-cycle pulse, frame end
- expected_len  input  LEN_WIDTH  bits expected; 0 = collect until postamble
- frame_dat  output  MAX_BITS  frame bits, right-aligned
- frame_len  output  LEN_WIDTH  number of valid bits in frame_dat
- frame_bank  output  BANK_WIDTH  in_bank latched at frame start
- frame_err  output  2  0 ok, 1 short, 2 overflow, 3 timeout
- crc_ok  output  1  CRC-16 residue check passed
- frame_vld  output  1  frame available
- frame_rdy  input  1  consumer accepts frame
- frame_drop  output  1  single-cycle pulse: preamble ignored while HOLD

Behaviour:
- Reset: state IDLE; frame_dat 0, frame_len 0, frame_bank 0, frame_err 0, crc_ok 0, frame_vld 0, frame_drop 0; bit counter, timeout counter, CRC register cleared/preset. Reset mid-frame or mid-HOLD discards everything.
- States: IDLE, COLLECT, HOLD.
- IDLE: on preamble_detected -> COLLECT; latch in_bank and expected_len (values > MAX_BITS clamp to MAX_BITS); clear buffer and count; preset CRC 0xFFFF. A bit with in_vld in the same cycle as the preamble pulse is discarded.
- COLLECT: each in_vld shifts in_dat into buffer LSB (first bit ends at frame_dat[frame_len-1]; unused upper bits 0); count += 1; CRC updated MSB-first, poly 0x1021; timeout counter cleared.
- Termination (go to HOLD, frame_vld = 1 on the next cycle):
  - count reaches latched expected_len -> err 0.
  - postamble_detected with count < expected_len -> err 1. If in_vld arrives in the same cycle, accept the bit first; if that bit completes the length, err 0.
  - expected_len = 0 and postamble -> err 0.
  - expected_len = 0 and count hits MAX_BITS with no postamble -> err 2.
  - timeout counter reaches TIMEOUT -> err 3; partial bits presented.
- preamble_detected during COLLECT (and not terminating): silent restart; buffer cleared, no frame emitted, new bank and length latched.
- crc_ok = (CRC register == 0x1D0F) and frame_len >= 16. Evaluated at termination and held with the frame.
- HOLD: all frame_* outputs stable while frame_vld = 1 and frame_rdy = 0. Transfer occurs on clk edge with frame_vld & frame_rdy -> IDLE, frame_vld = 0. In HOLD, in_vld is ignored; preamble_detected pulses frame_drop for 1 cycle. A preamble in the same cycle as the transfer also pulses frame_drop; that frame is lost.
- frame_rdy held high permanently gives a 1-cycle HOLD; back-to-back frames need at least one idle cycle.

Optional Feature:
- Macro CRC16_CHECK_EN.
- Defined: CRC logic as above; crc_ok reflects the residue check.
- Undefined: no CRC register is synthesized; crc_ok is tied to 1 and all other behaviour is unchanged.

Test Plan:
- expected_len = 16, preamble pulse, 16 bits 0xA5C3 (MSB first) -> frame_vld 1 cycle after 16th bit edge; frame_dat[15:0] = 0xA5C3, upper bits 0; frame_len = 16; frame_err = 0; frame_bank = latched in_bank (e.g. 2).
- expected_len = 32, payload 0x1234 followed by its bench-computed Gen2 CRC-16 -> crc_ok = 1, err 0. Same stimulus with bit 5 flipped -> crc_ok = 0. Without CRC16_CHECK_EN -> crc_ok = 1 in both cases.
- expected_len = 24, 10 bits then postamble -> frame_len = 10, frame_err = 1. Postamble on the same cycle as the 24th bit -> frame_len = 24, err 0.
- expected_len = 0, 130 bits without postamble (MAX_BITS = 128) -> frame_len = 128, err 2. 5 bits then 255 cycles with no in_vld -> frame_len = 5, err 3.
- frame_rdy held 0 for 50 cycles: outputs stable throughout; a preamble pulse during the wait -> frame_drop pulses once and the frame is unchanged. Preamble mid-COLLECT after 7 bits, then 16 new bits -> only one frame, containing the new 16 bits.
- rst asserted in COLLECT and again in HOLD -> next cycle all outputs at reset values; a following preamble plus 16 bits produces a clean frame.

Source files
------------

// File: rtl/gen2_frame_assembler.sv
// gen2_frame_assembler
// ---------------------------------------------------------------------------
// Collects the bit stream recovered by preamble_detector into one Gen2 tag
// reply frame (RN16, EPC, handle). A frame starts on a preamble pulse. It ends
// when the expected bit count is reached, on a postamble pulse, when the buffer
// is full (open-length frames only), or when in_vld stays idle too long. The
// frame is then presented over a valid/ready handshake.
//
// Optional feature: define CRC16_CHECK_EN to build the CRC-16 residue checker.
// Without it no CRC register exists and crc_ok is tied to 1.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_dat, in_vld      - recovered data bit and its strobe
//   in_bank             - frequency bank, latched at frame start
//   preamble_detected   - frame start pulse
//   postamble_detected  - frame end pulse
//   expected_len        - expected bit count (0 = until postamble)
//   frame_dat           - frame bits, right-aligned, first bit most significant
//   frame_len           - number of valid bits in frame_dat
//   frame_bank          - bank latched at frame start
//   frame_err           - 0 ok, 1 short, 2 overflow, 3 timeout
//   crc_ok              - CRC-16 residue check passed (frame_len >= 16)
//   frame_vld/frame_rdy - output handshake
//   frame_drop          - pulse: preamble ignored while a frame is held
// ---------------------------------------------------------------------------
module gen2_frame_assembler #(
  parameter int MAX_BITS = 128,
  parameter int BANKS    = 4,
  parameter int TIMEOUT  = 255,
  localparam int BANK_WIDTH = $clog2(BANKS),
  localparam int LEN_WIDTH  = $clog2(MAX_BITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_dat,
  input  logic                  in_vld,
  input  logic [BANK_WIDTH-1:0] in_bank,
  input  logic                  preamble_detected,
  input  logic                  postamble_detected,
  input  logic [LEN_WIDTH-1:0]  expected_len,
  output logic [MAX_BITS-1:0]   frame_dat,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic [BANK_WIDTH-1:0] frame_bank,
  output logic [1:0]            frame_err,
  output logic                  crc_ok,
  output logic                  frame_vld,
  input  logic                  frame_rdy,
  output logic                  frame_drop
);

  localparam int TMO_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(TIMEOUT);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX   = LEN_WIDTH'(MAX_BITS);

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_SHORT    = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                state_r;
  logic [MAX_BITS-1:0]   buf_r;
  logic [LEN_WIDTH-1:0]  cnt_r;
  logic [LEN_WIDTH-1:0]  exp_r;
  logic [TMO_WIDTH-1:0]  tmo_r;
  logic [BANK_WIDTH-1:0] bank_r;

  logic [MAX_BITS-1:0]   sh_buf_s;
  logic [LEN_WIDTH-1:0]  sh_cnt_s;
  logic [TMO_WIDTH-1:0]  tmo_nxt_s;
  logic                  term_s;
  logic [1:0]            err_s;

  // Requested lengths beyond the buffer size are limited to the buffer size.
  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
    if (len > LEN_MAX) begin
      return LEN_MAX;
    end else begin
      return len;
    end
  endfunction

`ifdef CRC16_CHECK_EN
  localparam logic [15:0] CRC_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

  logic [15:0] crc_r;
  logic [15:0] sh_crc_s;
  logic        crc_ok_s;

  // One MSB-first step of CRC-16/CCITT (poly 0x1021).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // CRC after the current cycle's bit; the residue test uses the updated count.
  always_comb begin
    sh_crc_s = crc_r;
    if (in_vld) begin
      sh_crc_s = crc16_step(crc_r, in_dat);
    end else begin
      sh_crc_s = crc_r;
    end
    crc_ok_s = (sh_crc_s == CRC_RESIDUE) && (sh_cnt_s >= LEN_WIDTH'(16));
  end
`else
  assign crc_ok = 1'b1;
`endif

  // Buffer/count/timeout after the current cycle, and termination decision.
  // The incoming bit is accepted before termination is judged, so a bit and a
  // postamble in the same cycle can still complete the frame.
  always_comb begin
    sh_buf_s  = buf_r;
    sh_cnt_s  = cnt_r;
    tmo_nxt_s = tmo_r + TMO_WIDTH'(1);
    if (in_vld) begin
      sh_buf_s  = {buf_r[MAX_BITS-2:0], in_dat};
      sh_cnt_s  = cnt_r + LEN_WIDTH'(1);
      tmo_nxt_s = '0;
    end else begin
      sh_buf_s  = buf_r;
      sh_cnt_s  = cnt_r;
    end

    term_s = 1'b0;
    err_s  = ERR_OK;
    if ((exp_r != '0) && (sh_cnt_s == exp_r)) begin
      term_s = 1'b1;
      err_s  = ERR_OK;
    end else if (postamble_detected) begin
      term_s = 1'b1;
      err_s  = (exp_r == '0) ? ERR_OK : ERR_SHORT;
    end else if ((exp_r == '0) && (sh_cnt_s == LEN_MAX)) begin
      term_s = 1'b1;
      err_s  = ERR_OVERFLOW;
    end else if (!in_vld && (tmo_nxt_s == TMO_LIMIT)) begin
      term_s = 1'b1;
      err_s  = ERR_TIMEOUT;
    end else begin
      term_s = 1'b0;
      err_s  = ERR_OK;
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      buf_r      <= '0;
      cnt_r      <= '0;
      exp_r      <= '0;
      tmo_r      <= '0;
      bank_r     <= '0;
      frame_dat  <= '0;
      frame_len  <= '0;
      frame_bank <= '0;
      frame_err  <= ERR_OK;
      frame_vld  <= 1'b0;
      frame_drop <= 1'b0;
`ifdef CRC16_CHECK_EN
      crc_r      <= CRC_PRESET;
      crc_ok     <= 1'b0;
`endif
    end else begin
      frame_drop <= 1'b0;
      case (state_r)
        IDLE: begin
          // A bit arriving together with the preamble belongs to the preamble.
          if (preamble_detected) begin
            state_r <= COLLECT;
            bank_r  <= in_bank;
            exp_r   <= clamp_len(expected_len);
            buf_r   <= '0;
            cnt_r   <= '0;
            tmo_r   <= '0;
`ifdef CRC16_CHECK_EN
            crc_r   <= CRC_PRESET;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        COLLECT: begin
          if (term_s) begin
            state_r    <= HOLD;
            frame_dat  <= sh_buf_s;
            frame_len  <= sh_cnt_s;
            frame_bank <= bank_r;
            frame_err  <= err_s;
            frame_vld  <= 1'b1;
`ifdef CRC16_CHECK_EN
            crc_ok     <= crc_ok_s;
`endif
          end else if (preamble_detected) begin
            // New preamble mid-frame: abandon the partial frame silently.
            state_r <= COLLECT;
            bank_r  <= in_bank;
            exp_r   <= clamp_len(expected_len);
            buf_r   <= '0;
            cnt_r   <= '0;
            tmo_r   <= '0;
`ifdef CRC16_CHECK_EN
            crc_r   <= CRC_PRESET;
`endif
          end else begin
            state_r <= COLLECT;
            buf_r   <= sh_buf_s;
            cnt_r   <= sh_cnt_s;
            tmo_r   <= tmo_nxt_s;
`ifdef CRC16_CHECK_EN
            crc_r   <= sh_crc_s;
`endif
          end
        end
        HOLD: begin
          // Input bits are ignored; a preamble here (even on the transfer
          // cycle) cannot start a frame and is reported as dropped.
          frame_drop <= preamble_detected;
          if (frame_rdy) begin
            state_r   <= IDLE;
            frame_vld <= 1'b0;
          end else begin
            state_r   <= HOLD;
          end
        end
        default: begin
          state_r   <= IDLE;
          frame_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gen2_frame_assembler.sv
// Self-checking bench for gen2_frame_assembler. Stimulus pushes the expected
// frame into a scoreboard queue; a monitor pops and compares on every frame
// transfer (frame_vld & frame_rdy). Build with +define+CRC16_CHECK_EN to
// exercise the CRC checker.
module tb_gen2_frame_assembler;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_dat;
  logic         in_vld;
  logic [1:0]   in_bank;
  logic         preamble_detected;
  logic         postamble_detected;
  logic [7:0]   expected_len;
  logic [127:0] frame_dat;
  logic [7:0]   frame_len;
  logic [1:0]   frame_bank;
  logic [1:0]   frame_err;
  logic         crc_ok;
  logic         frame_vld;
  logic         frame_rdy;
  logic         frame_drop;

  typedef struct packed {
    logic [127:0] dat;
    logic [7:0]   len;
    logic [1:0]   bank;
    logic [1:0]   err;
    logic         crc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef CRC16_CHECK_EN
  localparam logic CRC_RST  = 1'b0;
  localparam logic CRC_BAD  = 1'b0;
`else
  localparam logic CRC_RST  = 1'b1;
  localparam logic CRC_BAD  = 1'b1;
`endif

  gen2_frame_assembler dut (
    .clk                (clk),
    .rst                (rst),
    .in_dat             (in_dat),
    .in_vld             (in_vld),
    .in_bank            (in_bank),
    .preamble_detected  (preamble_detected),
    .postamble_detected (postamble_detected),
    .expected_len       (expected_len),
    .frame_dat          (frame_dat),
    .frame_len          (frame_len),
    .frame_bank         (frame_bank),
    .frame_err          (frame_err),
    .crc_ok             (crc_ok),
    .frame_vld          (frame_vld),
    .frame_rdy          (frame_rdy),
    .frame_drop         (frame_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference Gen2 CRC-16 register over the first n bits of v (MSB first).
  function automatic logic [15:0] crc_raw(input logic [127:0] v, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ v[i]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic exp_crc(input logic [127:0] v, input int n);
`ifdef CRC16_CHECK_EN
    return (crc_raw(v, n) == 16'h1D0F) && (n >= 16);
`else
    return 1'b1;
`endif
  endfunction

  // Monitor: every transfer must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && frame_vld && frame_rdy) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_frame: got len %0d dat %0h, required no frame", frame_len, frame_dat);
      end else begin
        mon_e = sb_q.pop_front();
        check("frame_dat",  frame_dat,            mon_e.dat);
        check("frame_len",  128'(frame_len),      128'(mon_e.len));
        check("frame_bank", 128'(frame_bank),     128'(mon_e.bank));
        check("frame_err",  128'(frame_err),      128'(mon_e.err));
        check("crc_ok",     128'(crc_ok),         128'(mon_e.crc));
      end
    end
  end

  task automatic cyc(input logic v, input logic d, input logic pre, input logic post);
    in_vld             = v;
    in_dat             = d;
    preamble_detected  = pre;
    postamble_detected = post;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start(input logic [1:0] bank, input logic [7:0] len);
    in_bank      = bank;
    expected_len = len;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic send(input logic [127:0] val, input int n, input logic post_last);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, val[i], 1'b0, post_last && (i == 0));
  endtask

  task automatic push(input logic [127:0] dat, input int len, input logic [1:0] bank,
                      input logic [1:0] err, input logic crc);
    exp_t e;
    e.dat  = dat;
    e.len  = 8'(len);
    e.bank = bank;
    e.err  = err;
    e.crc  = crc;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      idle(1);
      k++;
    end
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d frames pending, required 0", sb_q.size());
      sb_q.delete();
    end
    idle(2);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_vld"},  128'(frame_vld),  128'(0));
    check({tag, "_dat"},  frame_dat,        128'(0));
    check({tag, "_len"},  128'(frame_len),  128'(0));
    check({tag, "_bank"}, 128'(frame_bank), 128'(0));
    check({tag, "_err"},  128'(frame_err),  128'(0));
    check({tag, "_drop"}, 128'(frame_drop), 128'(0));
    check({tag, "_crc"},  128'(crc_ok),     128'(CRC_RST));
  endtask

  initial begin
    logic [127:0] w;
    logic [127:0] ovf;
    logic         b;

    rst = 1'b1; in_dat = 1'b0; in_vld = 1'b0; in_bank = 2'd0;
    preamble_detected = 1'b0; postamble_detected = 1'b0;
    expected_len = 8'd0; frame_rdy = 1'b1;
    idle(2);
    check_reset("reset");
    rst = 1'b0;
    idle(2);

    // Basic 16-bit frame on bank 2.
    start(2'd2, 8'd16);
    push(128'hA5C3, 16, 2'd2, 2'd0, exp_crc(128'hA5C3, 16));
    send(128'hA5C3, 16, 1'b0);
    check("basic_vld", 128'(frame_vld), 128'(1));
    wait_drain(20);

    // Payload 0x1234 plus its transmitted (complemented) CRC: good residue.
    w = 128'({16'h1234, ~crc_raw(128'h1234, 16)});
    start(2'd1, 8'd32);
    push(w, 32, 2'd1, 2'd0, 1'b1);
    send(w, 32, 1'b0);
    wait_drain(20);

    // Same frame with bit 5 flipped: residue fails.
    w = w ^ 128'h20;
    start(2'd1, 8'd32);
    push(w, 32, 2'd1, 2'd0, CRC_BAD);
    send(w, 32, 1'b0);
    wait_drain(20);

    // Short frame: 10 of 24 bits, then postamble.
    start(2'd3, 8'd24);
    push(128'h2B5, 10, 2'd3, 2'd1, exp_crc(128'h2B5, 10));
    send(128'h2B5, 10, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain(20);

    // Postamble together with the 24th bit completes the frame.
    start(2'd0, 8'd24);
    push(128'hC0FFEE, 24, 2'd0, 2'd0, exp_crc(128'hC0FFEE, 24));
    send(128'hC0FFEE, 24, 1'b1);
    wait_drain(20);

    // Open length ended by postamble.
    start(2'd2, 8'd0);
    push(128'hABCDE, 20, 2'd2, 2'd0, exp_crc(128'hABCDE, 20));
    send(128'hABCDE, 20, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain(20);

    // Open length overflow: 130 bits, only the first 128 kept.
    ovf = '0;
    for (int i = 0; i < 128; i++) begin
      b   = ((i * 7) % 5) < 2;
      ovf = {ovf[126:0], b};
    end
    start(2'd1, 8'd0);
    push(ovf, 128, 2'd1, 2'd2, exp_crc(ovf, 128));
    for (int i = 0; i < 130; i++) cyc(1'b1, ((i * 7) % 5) < 2, 1'b0, 1'b0);
    wait_drain(20);

    // Timeout: 5 bits then silence.
    start(2'd3, 8'd0);
    push(128'h16, 5, 2'd3, 2'd3, exp_crc(128'h16, 5));
    send(128'h16, 5, 1'b0);
    idle(254);
    check("tmo_not_yet", 128'(frame_vld), 128'(0));
    wait_drain(10);

    // Held frame stays stable for 50 cycles; a preamble during the wait is dropped.
    frame_rdy = 1'b0;
    start(2'd1, 8'd16);
    push(128'h5A5A, 16, 2'd1, 2'd0, exp_crc(128'h5A5A, 16));
    send(128'h5A5A, 16, 1'b0);
    for (int c = 0; c < 50; c++) begin
      cyc(c[0], 1'b1, c == 20, 1'b0);
      check("hold_vld",  128'(frame_vld),  128'(1));
      check("hold_dat",  frame_dat,        128'h5A5A);
      check("hold_len",  128'(frame_len),  128'(16));
      check("hold_drop", 128'(frame_drop), 128'(c == 20));
    end
    frame_rdy = 1'b1;
    wait_drain(20);

    // Restart after 7 bits: only the second frame appears.
    start(2'd0, 8'd16);
    send(128'h55, 7, 1'b0);
    start(2'd3, 8'd16);
    push(128'h3C96, 16, 2'd3, 2'd0, exp_crc(128'h3C96, 16));
    send(128'h3C96, 16, 1'b0);
    wait_drain(20);

    // Reset during COLLECT, then a clean frame.
    start(2'd2, 8'd16);
    send(128'hFF, 8, 1'b0);
    rst = 1'b1;
    idle(1);
    check_reset("rst_collect");
    rst = 1'b0;
    idle(1);
    start(2'd1, 8'd16);
    push(128'h0F0F, 16, 2'd1, 2'd0, exp_crc(128'h0F0F, 16));
    send(128'h0F0F, 16, 1'b0);
    wait_drain(20);

    // Reset during HOLD discards the frame, then a clean frame.
    frame_rdy = 1'b0;
    start(2'd3, 8'd16);
    send(128'hBEEF, 16, 1'b0);
    check("prerst_vld", 128'(frame_vld), 128'(1));
    rst = 1'b1;
    idle(1);
    check_reset("rst_hold");
    rst = 1'b0;
    frame_rdy = 1'b1;
    idle(3);
    start(2'd2, 8'd16);
    push(128'h1357, 16, 2'd2, 2'd0, exp_crc(128'h1357, 16));
    send(128'h1357, 16, 1'b0);
    wait_drain(20);

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
